res_dump_ctrl: RTL
==================

RES_DUMP_CTRL -- requirements
Module: res_dump_ctrl

Interface
REQ-001 Parameter C1_LANES, 40, bytes per conv1 output beat.
REQ-002 Parameter C1_BEATS, 64, conv1 beats per frame; conv1 length = C1_LANES*C1_BEATS = 2560.
REQ-003 Parameter C2_LEN, 1152, conv2 bytes, all present in every conv2 beat.
REQ-004 Parameter C3_LANES, 36, bytes per conv3 output beat.
REQ-005 Parameter C3_BEATS, 32, conv3 beats per frame; conv3 length = 1152.
REQ-006 Parameter TIMEOUT_CYC, 65535, ARM watchdog limit in cycles (used only under REQ-034).
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle request to dump one whole layer.
REQ-010 layer_sel  in  2  layer to dump (1, 2 or 3); 0 is invalid; sampled on accepted start.
REQ-011 conv1_valid_o_rescaled / conv2_valid_o_rescaled / conv3_valid_o_rescaled  in  1 each  layer output beat strobes.
REQ-012 conv1_res_test / conv2_res_test / conv3_res_test  in  8 each  registered probe bytes from the result-test block.
REQ-013 res_sel_1  out  12; res_sel_2  out  11; res_sel_3  out  11  flat element index driven to the result-test block.
REQ-014 dump_data  out  8; dump_idx  out  12; dump_layer  out  2; dump_valid  out  1  output stream.
REQ-015 dump_ready  in  1  downstream accept.
REQ-016 busy  out  1; done  out  1 (one-cycle pulse); err  out  1 (sticky until next accepted start).

Function
REQ-017 FSM states: IDLE, ARM, CAPT, SEND, NEXT, FIN.
REQ-018 IDLE: start with layer_sel in 1..3 is accepted; the layer is latched; idx = 0; state goes to ARM; start is ignored when layer_sel = 0 or when not in IDLE.
REQ-019 The block keeps free-running mirror beat counters: conv1 counts 0..63 and conv3 counts 0..31 on each valid, wrapping to 0; both run in every state.
REQ-020 idx is decomposed into (beat, lane) registers that are updated incrementally; no divider or modulo is used.
REQ-021 The selected layer's res_sel output equals idx, registered, and is stable for the whole of ARM; the other two res_sel outputs hold 0.
REQ-022 ARM -> CAPT fires on a cycle when the selected layer's valid = 1 and its mirror count = target beat; for conv2 any valid qualifies.
REQ-023 CAPT lasts exactly one cycle; the selected *_res_test byte is sampled at the end of CAPT, one cycle after the matching valid.
REQ-024 SEND: dump_valid = 1; dump_data, dump_idx and dump_layer are held stable until dump_valid & dump_ready; the handshake moves to NEXT.
REQ-025 NEXT: if idx = layer length-1, go to FIN; otherwise idx+1 (lane wraps at C1_LANES/C3_LANES with beat+1) and go to ARM.
REQ-026 FIN: done = 1 for one cycle, then IDLE.
REQ-027 busy = 1 in every state except IDLE.
REQ-028 A valid on a non-selected layer has no effect other than advancing that layer's mirror counter.
REQ-029 Throughput: one element per matching frame beat at most; consecutive elements in the same beat wait for the next frame.

Reset
REQ-030 On rst: state = IDLE; mirror counters, idx, res_sel_*, dump_*, busy, done and err are all 0.
REQ-031 rst asserted mid-dump aborts immediately; no partial done is issued; the next start begins again at idx 0.

Configuration
REQ-032 Macro RES_DUMP_TIMEOUT_EN.
REQ-033 Without the macro, ARM waits indefinitely and err is tied to 0.
REQ-034 With the macro, a cycle counter clears on ARM entry; if it reaches TIMEOUT_CYC while in ARM: err = 1, state goes to FIN (done pulses), and the dump aborts.

Verification
REQ-035 Layer 2 dump, dump_ready = 1, a conv2 valid every 4 cycles -> 1152 beats, dump_idx 0..1151 in order, one done pulse, busy is low afterwards.
REQ-036 Layer 1, idx 39 -> 40 boundary -> res_sel_1 goes 39 then 40; the capture for 40 happens on conv1 mirror count 1, not 0.
REQ-037 Layer 3, dump_ready held low 10 cycles in SEND -> dump_data and dump_idx are unchanged, and no extra conv3 captures are taken.
REQ-038 start with layer_sel = 0, or start while busy -> ignored; state and outputs are unchanged.
REQ-039 rst pulsed at idx 500 of layer 1 -> all outputs are 0 next cycle; a restart emits idx 0 first.
REQ-040 RES_DUMP_TIMEOUT_EN defined, layer 3, no conv3 valid -> after 65535 cycles err = 1, done pulses once, busy = 0.

Source files
------------

// File: rtl/res_dump_ctrl.sv
// res_dump_ctrl: streams one layer's result buffer (conv1, conv2 or conv3) out
// element by element. For each flat index it drives res_sel_* to the
// result-test block, waits for the frame beat that carries that element,
// samples the probe byte one cycle later and hands it out on a valid/ready
// stream.
// Optional feature: define RES_DUMP_TIMEOUT_EN to add an ARM watchdog that
// raises err and ends the dump when no matching beat arrives in time.
//
// Handshake: dump_valid rises with dump_data/dump_idx/dump_layer already
// stable; all three hold until the cycle where dump_valid & dump_ready are
// both high. dump_valid never drops without that handshake, except on rst.
module res_dump_ctrl #(
  parameter int C1_LANES    = 40,
  parameter int C1_BEATS    = 64,
  parameter int C2_LEN      = 1152,
  parameter int C3_LANES    = 36,
  parameter int C3_BEATS    = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  layer_sel,
  input  logic        conv1_valid_o_rescaled,
  input  logic        conv2_valid_o_rescaled,
  input  logic        conv3_valid_o_rescaled,
  input  logic [7:0]  conv1_res_test,
  input  logic [7:0]  conv2_res_test,
  input  logic [7:0]  conv3_res_test,
  output logic [11:0] res_sel_1,
  output logic [10:0] res_sel_2,
  output logic [10:0] res_sel_3,
  output logic [7:0]  dump_data,
  output logic [11:0] dump_idx,
  output logic [1:0]  dump_layer,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state
);

  localparam int C1_CW    = $clog2(C1_BEATS);
  localparam int C3_CW    = $clog2(C3_BEATS);
  localparam int BEAT_W   = (C1_CW > C3_CW) ? C1_CW : C3_CW;
  localparam int LANE_MAX = (C1_LANES > C3_LANES) ? C1_LANES : C3_LANES;
  localparam int LANE_W   = $clog2(LANE_MAX);
  localparam int C1_LEN   = C1_LANES * C1_BEATS;
  localparam int C3_LEN   = C3_LANES * C3_BEATS;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_CAPT = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [1:0]        r_layer;
  logic [11:0]       r_idx;
  logic [LANE_W-1:0] r_lane;
  logic [BEAT_W-1:0] r_beat;
  logic [C1_CW-1:0]  r_c1_cnt;
  logic [C3_CW-1:0]  r_c3_cnt;
  logic [11:0]       r_res_sel_1;
  logic [10:0]       r_res_sel_2;
  logic [10:0]       r_res_sel_3;
  logic [7:0]        r_dump_data;
  logic [11:0]       r_dump_idx;
  logic [1:0]        r_dump_layer;
  logic              r_dump_valid;

  logic              w_accept;
  logic              w_hit;
  logic              w_last;
  logic              w_lane_wrap;
  logic              w_tmo;
  logic [11:0]       w_len_m1;
  logic [LANE_W-1:0] w_lane_last;
  logic [11:0]       w_idx_inc;
  logic [7:0]        w_probe;

  assign w_accept  = (r_state == S_IDLE) && start && (layer_sel != 2'd0);
  assign w_idx_inc = r_idx + 12'd1;
  assign w_last    = (r_idx == w_len_m1);
  assign w_lane_wrap = (r_lane == w_lane_last);

  // Per-layer constants and the "this beat carries our element" qualifier
  always_comb begin
    w_hit       = 1'b0;
    w_len_m1    = 12'(C3_LEN - 1);
    w_lane_last = LANE_W'(C3_LANES - 1);
    w_probe     = conv3_res_test;
    case (r_layer)
      2'd1: begin
        w_hit       = conv1_valid_o_rescaled && (r_c1_cnt == r_beat[C1_CW-1:0]);
        w_len_m1    = 12'(C1_LEN - 1);
        w_lane_last = LANE_W'(C1_LANES - 1);
        w_probe     = conv1_res_test;
      end
      2'd2: begin
        w_hit    = conv2_valid_o_rescaled;
        w_len_m1 = 12'(C2_LEN - 1);
        w_probe  = conv2_res_test;
      end
      2'd3: begin
        w_hit = conv3_valid_o_rescaled && (r_c3_cnt == r_beat[C3_CW-1:0]);
      end
      default: begin
        w_hit = 1'b0;
      end
    endcase
  end

  // Next-state decode for the dump sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_ARM;
      S_ARM: begin
        if (w_hit)      w_state_nxt = S_CAPT;
        else if (w_tmo) w_state_nxt = S_FIN;
      end
      S_CAPT: w_state_nxt = S_SEND;
      S_SEND: if (dump_ready) w_state_nxt = S_NEXT;
      S_NEXT: w_state_nxt = w_last ? S_FIN : S_ARM;
      S_FIN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Free-running mirrors of the producers' beat position within a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c1_cnt <= '0;
      r_c3_cnt <= '0;
    end else begin
      if (conv1_valid_o_rescaled)
        r_c1_cnt <= (r_c1_cnt == C1_CW'(C1_BEATS - 1)) ? '0 : r_c1_cnt + C1_CW'(1);
      if (conv3_valid_o_rescaled)
        r_c3_cnt <= (r_c3_cnt == C3_CW'(C3_BEATS - 1)) ? '0 : r_c3_cnt + C3_CW'(1);
    end
  end

  // Element index walk (idx plus its beat/lane split) and res_sel drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_layer     <= 2'd0;
      r_idx       <= 12'd0;
      r_lane      <= '0;
      r_beat      <= '0;
      r_res_sel_1 <= 12'd0;
      r_res_sel_2 <= 11'd0;
      r_res_sel_3 <= 11'd0;
    end else if (w_accept) begin
      r_layer     <= layer_sel;
      r_idx       <= 12'd0;
      r_lane      <= '0;
      r_beat      <= '0;
      r_res_sel_1 <= 12'd0;
      r_res_sel_2 <= 11'd0;
      r_res_sel_3 <= 11'd0;
    end else if ((r_state == S_NEXT) && !w_last) begin
      r_idx <= w_idx_inc;
      // conv2 delivers every element in every beat, so its split is unused
      if (r_layer != 2'd2) begin
        if (w_lane_wrap) begin
          r_lane <= '0;
          r_beat <= r_beat + BEAT_W'(1);
        end else begin
          r_lane <= r_lane + LANE_W'(1);
        end
      end
      case (r_layer)
        2'd1:    r_res_sel_1 <= w_idx_inc;
        2'd2:    r_res_sel_2 <= w_idx_inc[10:0];
        default: r_res_sel_3 <= w_idx_inc[10:0];
      endcase
    end
  end

  // Output stream register: loaded at the end of CAPT, released on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dump_data  <= 8'd0;
      r_dump_idx   <= 12'd0;
      r_dump_layer <= 2'd0;
      r_dump_valid <= 1'b0;
    end else if (r_state == S_CAPT) begin
      r_dump_data  <= w_probe;
      r_dump_idx   <= r_idx;
      r_dump_layer <= r_layer;
      r_dump_valid <= 1'b1;
    end else if ((r_state == S_SEND) && dump_ready) begin
      r_dump_valid <= 1'b0;
    end
  end

`ifdef RES_DUMP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  assign w_tmo = (r_state == S_ARM) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign err   = r_err;

  // Watchdog: counts cycles spent in the current ARM visit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_tmo_cnt <= '0;
    else if (r_state != S_ARM)  r_tmo_cnt <= '0;
    else                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  // Sticky error flag, cleared only by the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_err <= 1'b0;
    else if (w_accept)          r_err <= 1'b0;
    else if (w_tmo && !w_hit)   r_err <= 1'b1;
  end
`else
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

  assign res_sel_1  = r_res_sel_1;
  assign res_sel_2  = r_res_sel_2;
  assign res_sel_3  = r_res_sel_3;
  assign dump_data  = r_dump_data;
  assign dump_idx   = r_dump_idx;
  assign dump_layer = r_dump_layer;
  assign dump_valid = r_dump_valid;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FIN);
  assign dbg_state  = r_state;

endmodule
